// File: rtl/parity_frame_sequencer.sv
// parity_frame_sequencer
//
// Accepts a parallel word over a valid/ready handshake and sends it LSB-first
// on a single idle-high serial line as: start(0), DATA_W data bits, parity,
// stop(1). Each serial bit is held for CLKS_PER_BIT clocks. Parity mode
// (even/odd) is chosen per frame and the computed parity bit is exposed.
//
// Ports:
//   i_clk    system clock, rising edge
//   i_rst    asynchronous, active-high reset
//   i_data   parallel word to send (sampled only on the handshake edge)
//   i_valid  producer has a word on i_data
//   i_odd    parity mode for this frame: 0 = even, 1 = odd
//   o_ready  sequencer can accept a word (combinational)
//   o_tx     serial line, idle-high (registered)
//   o_par    parity bit of the current/last frame (registered)
//   o_busy   frame in progress (registered)
//   o_done   one-cycle pulse in the final stop-bit cycle (registered)
module parity_frame_sequencer #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    input  logic              i_odd,
    output logic              o_ready,
    output logic              o_tx,
    output logic              o_par,
    output logic              o_busy,
    output logic              o_done
);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              par_q, par_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept;
    logic              bit_end;

    assign o_ready = (state_q == S_IDLE) && !i_rst;
    assign accept  = i_valid && o_ready;
    assign bit_end = (clk_cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;

        // The clock counter runs in every framing state and wraps on each
        // bit boundary, so it is back at zero whenever the block is idle.
        if (state_q != S_IDLE) begin
            clk_cnt_d = bit_end ? '0 : clk_cnt_q + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_START;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    shift_d   = i_data;
                    par_d     = (^i_data) ^ i_odd;
                end
            end
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = S_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_end) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are derived from the next state:
        // the line value seen in a cycle belongs to the state of that cycle.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_STOP) && (clk_cnt_d == CNT_LAST);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            par_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            par_q     <= par_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // The shift register is pure data: it is always loaded before use.
    always_ff @(posedge i_clk) begin
        shift_q <= shift_d;
    end

    assign o_tx   = tx_q;
    assign o_par  = par_q;
    assign o_busy = busy_q;
    assign o_done = done_q;
endmodule

// File: tb/tb_parity_frame_sequencer.sv
// Testbench for parity_frame_sequencer.
// Main instance: DATA_W=8, CLKS_PER_BIT=4, checked through a scoreboard of
// expected frames. Second instance: DATA_W=1, CLKS_PER_BIT=1, checked directly.
module tb_parity_frame_sequencer;
    localparam int DW = 8;
    localparam int C  = 4;
    localparam int L  = (DW + 3) * C;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] i_data = '0;
    logic          i_valid = 1'b0;
    logic          i_odd = 1'b0;
    logic          o_ready, o_tx, o_par, o_busy, o_done;

    logic [0:0]    d2_data = 1'b0;
    logic          d2_valid = 1'b0;
    logic          d2_odd = 1'b0;
    logic          d2_ready, d2_tx, d2_par, d2_busy, d2_done;

    always #5 clk = ~clk;

    parity_frame_sequencer #(.DATA_W(DW), .CLKS_PER_BIT(C)) dut (
        .i_clk(clk), .i_rst(rst), .i_data(i_data), .i_valid(i_valid), .i_odd(i_odd),
        .o_ready(o_ready), .o_tx(o_tx), .o_par(o_par), .o_busy(o_busy), .o_done(o_done)
    );

    parity_frame_sequencer #(.DATA_W(1), .CLKS_PER_BIT(1)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_data(d2_data), .i_valid(d2_valid), .i_odd(d2_odd),
        .o_ready(d2_ready), .o_tx(d2_tx), .o_par(d2_par), .o_busy(d2_busy), .o_done(d2_done)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          odd;
        int            t;
    } frame_t;

    frame_t sb[$];
    int     n_checks = 0;
    int     n_pass = 0;
    int     cyc = 0;
    int     hs_cnt = 0;
    int     last_hs_t = 0;

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Parity bit chosen so that data plus parity has the required count of ones.
    function automatic logic model_parity(input logic [DW-1:0] d, input logic odd);
        int ones = $countones(d);
        return ((ones % 2) == (odd ? 1 : 0)) ? 1'b0 : 1'b1;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: samples on the falling edge, collects the serial line while
    // busy and checks a complete frame against the scoreboard on o_done.
    initial begin
        logic   cap[$];
        logic   exp_bits[$];
        logic   sym[$];
        bit     prev_done = 0;
        frame_t f;
        int     bad;
        int     first_bad;
        forever begin
            @(negedge clk);
            if (rst) begin
                cap.delete();
                sb.delete();
                prev_done = 0;
            end else begin
                if (prev_done) begin
                    check("ready_after_done", o_ready == 1'b1, o_ready, 1);
                    check("busy_after_done", o_busy == 1'b0, o_busy, 0);
                end
                if (o_busy) cap.push_back(o_tx);
                else if (o_tx !== 1'b1) check("idle_tx_high", 0, o_tx, 1);
                if (o_done) begin
                    if (sb.size() == 0) begin
                        check("done_without_frame", 0, 1, 0);
                    end else begin
                        f = sb.pop_front();
                        sym.delete();
                        sym.push_back(1'b0);
                        for (int i = 0; i < DW; i++) sym.push_back(f.data[i]);
                        sym.push_back(model_parity(f.data, f.odd));
                        sym.push_back(1'b1);
                        exp_bits.delete();
                        foreach (sym[s]) for (int r = 0; r < C; r++) exp_bits.push_back(sym[s]);
                        bad = 0;
                        first_bad = -1;
                        if (cap.size() != exp_bits.size()) begin
                            bad = 1;
                        end else begin
                            foreach (cap[i]) if (cap[i] !== exp_bits[i]) begin
                                bad++;
                                if (first_bad < 0) first_bad = i;
                            end
                        end
                        if (bad != 0)
                            $display("FAIL frame_bits: data=%02h odd=%0d len %0d/%0d first bad bit idx %0d",
                                     f.data, f.odd, cap.size(), exp_bits.size(), first_bad);
                        n_checks++;
                        if (bad == 0) n_pass++;
                        check("done_latency", (cyc - f.t) == L, cyc - f.t, L);
                        check("o_par", o_par == model_parity(f.data, f.odd), o_par,
                              model_parity(f.data, f.odd));
                    end
                    cap.delete();
                end
                prev_done = o_done;
                // Handshake will occur on the coming rising edge.
                if (i_valid && o_ready) begin
                    sb.push_back('{data: i_data, odd: i_odd, t: cyc});
                    hs_cnt++;
                    last_hs_t = cyc;
                end
            end
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic odd, input bit hold, output int t);
        int start = hs_cnt;
        bit got = 0;
        i_data  = d;
        i_odd   = odd;
        i_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #2;
            if (hs_cnt != start) begin
                got = 1;
                break;
            end
        end
        if (!hold) i_valid = 1'b0;
        t = last_hs_t;
        if (!got) check("handshake_timeout", 0, 0, 1);
    endtask

    task automatic wait_idle();
        bit got = 0;
        for (int k = 0; k < 200; k++) begin
            if (o_ready) begin
                got = 1;
                break;
            end
            i_data = DW'($urandom);
            i_odd  = 1'($urandom);
            @(posedge clk);
            #2;
        end
        if (!got) check("idle_timeout", 0, 0, 1);
    endtask

    initial begin
        int t1, t2, start, k2;
        logic [3:0] seq2;
        logic [DW-1:0] d;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_ready", o_ready == 1'b0, o_ready, 0);
        check("rst_tx", o_tx == 1'b1, o_tx, 1);
        check("rst_busy", o_busy == 1'b0, o_busy, 0);
        check("rst_done", o_done == 1'b0, o_done, 0);
        check("rst_par", o_par == 1'b0, o_par, 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", o_ready == 1'b1, o_ready, 1);
        @(posedge clk);
        #2;

        // Reset mid-frame
        send(8'hA5, 1'b0, 0, t1);
        repeat (19) @(posedge clk);
        #2;
        check("pre_rst_busy", o_busy == 1'b1, o_busy, 1);
        rst = 1'b1;
        #1;
        check("midrst_tx", o_tx == 1'b1, o_tx, 1);
        check("midrst_busy", o_busy == 1'b0, o_busy, 0);
        check("midrst_done", o_done == 1'b0, o_done, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #2;
            check("rst_hold_tx", o_tx == 1'b1, o_tx, 1);
            check("rst_hold_done", o_done == 1'b0, o_done, 0);
        end
        rst = 1'b0;
        #1;
        check("ready_after_midrst", o_ready == 1'b1, o_ready, 1);
        @(posedge clk);
        #2;
        send(8'h3C, 1'b0, 0, t1);
        wait_idle();
        check("par_3C_even", o_par == 1'b0, o_par, 0);

        // 0xA5 even, then 0x07 odd and even
        send(8'hA5, 1'b0, 0, t1);
        wait_idle();
        check("par_A5_even", o_par == 1'b0, o_par, 0);
        send(8'h07, 1'b1, 0, t1);
        wait_idle();
        check("par_07_odd", o_par == 1'b0, o_par, 0);
        send(8'h07, 1'b0, 0, t1);
        wait_idle();
        check("par_07_even", o_par == 1'b1, o_par, 1);

        // Back-to-back with i_valid held high; data changes mid-frame
        send(8'hFF, 1'b0, 1, t1);
        check("b2b_par0", o_par == 1'b0, o_par, 0);
        send(8'h00, 1'b1, 0, t2);
        check("b2b_spacing", (t2 - t1) == L + 1, t2 - t1, L + 1);
        check("b2b_par1", o_par == 1'b1, o_par, 1);
        wait_idle();

        // i_valid pulsed while busy is ignored
        send(DW'($urandom), 1'($urandom), 0, t1);
        start = hs_cnt;
        for (int k = 0; k < 30; k++) begin
            i_valid = 1'($urandom);
            i_data  = DW'($urandom);
            i_odd   = 1'($urandom);
            @(posedge clk);
            #2;
        end
        i_valid = 1'b0;
        check("no_restart", hs_cnt == start, hs_cnt, start);
        wait_idle();

        // Idle for 20 cycles
        start = hs_cnt;
        repeat (20) @(posedge clk);
        #2;
        check("idle_tx", o_tx == 1'b1, o_tx, 1);
        check("idle_ready", o_ready == 1'b1, o_ready, 1);
        check("idle_busy", o_busy == 1'b0, o_busy, 0);
        check("idle_no_hs", hs_cnt == start, hs_cnt, start);

        // Randomized frames with random gaps and occasional back-to-back
        for (int n = 0; n < 30; n++) begin
            bit hold;
            d = DW'($urandom);
            hold = 1'($urandom);
            send(d, 1'($urandom), hold, t1);
            if (!hold) repeat ($urandom_range(0, 50)) @(posedge clk);
            #0;
        end
        i_valid = 1'b0;
        wait_idle();
        repeat (2) @(posedge clk);
        #2;
        check("scoreboard_empty", sb.size() == 0, sb.size(), 0);

        // DATA_W=1, CLKS_PER_BIT=1: data=1 odd -> 0,1,0,1
        seq2 = 4'b1010;
        d2_data = 1'b1;
        d2_odd = 1'b1;
        check("d2_ready", d2_ready == 1'b1, d2_ready, 1);
        d2_valid = 1'b1;
        @(posedge clk);
        #2;
        d2_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            k2 = k;
            check("d2_tx", d2_tx == seq2[k2 - 1], d2_tx, seq2[k2 - 1]);
            check("d2_done", d2_done == (k2 == 4), d2_done, (k2 == 4));
            @(posedge clk);
            #2;
        end
        check("d2_ready_back", d2_ready == 1'b1, d2_ready, 1);
        check("d2_par", d2_par == 1'b0, d2_par, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end
endmodule

// File: doc/parity_frame_sequencer.md
Name: parity_frame_sequencer

Overview:
Controller that sequences serial parity generation for a parallel word. It accepts a DATA_W-bit word over a valid/ready handshake and shifts it out LSB-first on a single serial line, framed as start bit, data bits, parity bit, stop bit. Each bit is held for CLKS_PER_BIT clocks. Parity mode (even/odd) is selectable per frame. It sits between a parallel producer and the serial parity/line datapath.

Parameters:
DATA_W, 8, number of data bits per frame (min 1)
CLKS_PER_BIT, 4, clock cycles each serial bit is held (min 1)

Ports:
i_clk  input  1  system clock, rising-edge
i_rst  input  1  reset, asynchronous, active-high
i_data  input  DATA_W  parallel word to send
i_valid  input  1  producer has a word on i_data
i_odd  input  1  parity mode for this frame: 0 = even, 1 = odd
o_ready  output  1  sequencer can accept a word
o_tx  output  1  serial line, idle-high
o_par  output  1  parity bit of the current/last frame
o_busy  output  1  frame in progress
o_done  output  1  one-cycle pulse at frame end

Behaviour:
- Clocking/reset: one clock i_clk; reset i_rst is asynchronous and active-high.
- Reset values: state=IDLE, o_tx=1, o_par=0, o_busy=0, o_done=0, bit and clock counters=0. o_ready=0 while i_rst is high.
- All outputs are registered except o_ready. o_ready = (state==IDLE) && !i_rst.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: o_tx=1.
  - A handshake (i_valid && o_ready at the rising edge T) latches i_data into a shift register.
  - The same edge latches i_odd and computes o_par = ^i_data ^ i_odd.
  - Next state is START. o_busy=1 from T+1.
  - i_valid low keeps the block in IDLE. i_data and i_odd are ignored outside the handshake edge.
- START: o_tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: o_tx = shift_reg[0], one bit per CLKS_PER_BIT cycles, LSB first. After bit DATA_W-1, go to PARITY.
- PARITY: o_tx=o_par for CLKS_PER_BIT cycles, then STOP.
- STOP: o_tx=1 for CLKS_PER_BIT cycles. o_done=1 during the final STOP cycle only, then IDLE.
- o_busy: 1 in START/DATA/PARITY/STOP, 0 in IDLE.
- Timing from handshake edge T, with L=(DATA_W+3)*CLKS_PER_BIT:
  - Start bit occupies T+1..T+CLKS_PER_BIT.
  - o_done is high at T+L.
  - o_ready returns at T+L+1.
- Back-to-back: a new handshake is allowed in the first IDLE cycle. Minimum spacing is one idle-high cycle between frames.
- o_par holds its value until the next handshake.
- Clock counter wraps from CLKS_PER_BIT-1 to 0 on each bit boundary. With CLKS_PER_BIT=1 every state lasts exactly one cycle.
- Bit counter width is clog2(DATA_W), minimum 1. DATA_W=1 sends exactly one data bit.
- Reset mid-frame: o_tx goes to 1 immediately (asynchronous). The frame is abandoned, no o_done is produced, and state returns to IDLE.
- Parity rule: data plus parity bit contain an even number of ones in even mode and an odd number in odd mode.

Test Plan:
- Reset mid-frame: reset, then 0xA5 even (DATA_W=8, CLKS_PER_BIT=4); assert i_rst at T+20. Required: o_tx=1, o_busy=0, o_done=0 immediately and throughout; o_ready=1 after release; a subsequent 0x3C even frame is correct (o_par=0).
- 0xA5, i_odd=0:
  - o_tx sequence per 4 cycles is 0 | 1,0,1,0,0,1,0,1 | 0 | 1.
  - o_par=0, o_done at T+44, o_ready at T+45.
- 0x07, i_odd=1: o_par=0, parity slot T+37..T+40 low. 0x07 with i_odd=0: o_par=1, parity slot high.
- Back-to-back:
  - i_valid held high with 0xFF even then 0x00 odd.
  - Second handshake occurs at T+45, exactly one idle-high cycle between frames.
  - Parities are 0 then 1.
  - i_data changed mid-frame does not alter the shifted bits.
- Handshake gating: i_valid pulsed while o_busy=1 is ignored (no frame restart, o_tx unaffected). i_valid=0 for 20 cycles gives o_tx=1, o_ready=1, o_busy=0.
- CLKS_PER_BIT=1, DATA_W=1: data=1 in odd mode gives o_tx = 0,1,0,1 over four cycles, o_done at T+4.
